// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronise/debounce the two coin sensors, queue coin events and feed the vending FSM one x code per coin.
// Define COIN_ACCEPTOR_STATS_EN to add the saturating credit_total output.

module coin_acceptor_chan #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);
    localparam int CW = 8;

    logic [1:0]    sync;
    logic          deb;
    logic [CW-1:0] cnt;
    logic          flip;

    // flip is decided one cycle ahead so the event lands on the same edge as the level change
    assign flip = (sync[1] != deb) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise = flip && !deb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b00;
            deb  <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (flip) begin
                deb <= ~deb;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEPTH           = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         coin5_raw,
    input  logic                         coin10_raw,
    input  logic                         hold,
    output logic [1:0]                   x,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
`ifdef COIN_ACCEPTOR_STATS_EN
    output logic [15:0]                  credit_total,
`endif
    output logic                         coin_return
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    localparam int FW = OW + 1;

    typedef struct packed {
        logic       vld;
        logic [1:0] code;
    } push_t;

    logic [1:0]    raw;
    logic [1:0]    ev;
    logic [1:0]    mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW-1:0] wp_nx1;
    logic          pop;
    logic [FW-1:0] free;
    push_t [1:0]   wr;
    logic [1:0]    nwr;
    logic [1:0]    nrej;
    logic [1:0]    ret_tot;
    logic          ret_pend;

    assign raw = {coin10_raw, coin5_raw};

    for (genvar i = 0; i < 2; i++) begin : g_chan
        coin_acceptor_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[i]),
            .rise  (ev[i])
        );
    end

    assign pop    = (pending != '0) && !hold;
    assign free   = FW'(DEPTH) - {1'b0, pending} + FW'(pop);
    assign wp_nx1 = wp + PW'(1);

    // 5-unit coin always takes the first free slot; the 10-unit one goes second
    always_comb begin
        wr[0] = '0;
        wr[1] = '0;
        nrej  = 2'd0;
        case (ev)
            2'b01, 2'b10: begin
                if (free != '0) begin
                    wr[0].vld  = 1'b1;
                    wr[0].code = ev;
                end else begin
                    nrej = 2'd1;
                end
            end
            2'b11: begin
                if (free >= FW'(2)) begin
                    wr[0] = '{vld: 1'b1, code: 2'b01};
                    wr[1] = '{vld: 1'b1, code: 2'b10};
                end else if (free == FW'(1)) begin
                    wr[0] = '{vld: 1'b1, code: 2'b01};
                    nrej  = 2'd1;
                end else begin
                    nrej  = 2'd2;
                end
            end
            default: ;
        endcase
    end

    assign nwr     = {1'b0, wr[0].vld} + {1'b0, wr[1].vld};
    assign ret_tot = {1'b0, ret_pend} + nrej;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
            wp          <= '0;
            rp          <= '0;
            pending     <= '0;
            x           <= 2'b00;
            coin_return <= 1'b0;
            ret_pend    <= 1'b0;
        end else begin
            if (wr[0].vld) mem[wp]     <= wr[0].code;
            if (wr[1].vld) mem[wp_nx1] <= wr[1].code;
            wp <= wp + PW'(nwr);
            if (pop) rp <= rp + PW'(1);
            x           <= pop ? mem[rp] : 2'b00;
            pending     <= pending + OW'(nwr) - OW'(pop);
            // a double rejection is stretched over two cycles via ret_pend
            coin_return <= (ret_tot != 2'd0);
            ret_pend    <= ret_tot[1];
        end
    end

`ifdef COIN_ACCEPTOR_STATS_EN
    logic [16:0] credit_sum;

    always_comb begin
        credit_sum = {1'b0, credit_total};
        if (x == 2'b01)      credit_sum = credit_sum + 17'd5;
        else if (x == 2'b10) credit_sum = credit_sum + 17'd10;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) credit_total <= 16'h0000;
        else        credit_total <= credit_sum[16] ? 16'hFFFF : credit_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor (DEBOUNCE_CYCLES=4, DEPTH=4); STATS checks when COIN_ACCEPTOR_STATS_EN is defined.

module tb_coin_acceptor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        coin5_raw = 1'b0;
    logic        coin10_raw = 1'b0;
    logic        hold = 1'b0;
    logic [1:0]  x;
    logic [2:0]  pending;
    logic        coin_return;
`ifdef COIN_ACCEPTOR_STATS_EN
    logic [15:0] credit_total;
`endif

    int          checks = 0;
    int          failures = 0;
    int          ret_cnt = 0;
    logic [31:0] hist = '0;
    logic [1:0]  drain_exp [5];

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(4), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .coin5_raw    (coin5_raw),
        .coin10_raw   (coin10_raw),
        .hold         (hold),
        .x            (x),
        .pending      (pending),
`ifdef COIN_ACCEPTOR_STATS_EN
        .credit_total (credit_total),
`endif
        .coin_return  (coin_return)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // raise the selected sensors for 8 cycles, then let them settle low for 8
    task automatic insert(input logic [1:0] m);
        coin5_raw  = m[0];
        coin10_raw = m[1];
        repeat (8) begin
            @(negedge clk);
            hist = {hist[30:0], coin_return};
            if (coin_return) ret_cnt++;
        end
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            hist = {hist[30:0], coin_return};
            if (coin_return) ret_cnt++;
        end
    endtask

    initial begin
        #3 reset = 1'b0;
        #10;
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ret", 32'(coin_return), 32'd0);
`ifdef COIN_ACCEPTOR_STATS_EN
        chk("rst_credit", 32'(credit_total), 32'd0);
`endif
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);

        // clean 5-unit coin: code visible after E0+6
        coin5_raw = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            chk($sformatf("clean_x_%0d", i), 32'(x), (i == 7) ? 32'd1 : 32'd0);
            if (i == 6) chk("clean_pending", 32'(pending), 32'd1);
            if (i == 10) coin5_raw = 1'b0;
        end
        repeat (6) @(negedge clk);
        chk("clean_pending_end", 32'(pending), 32'd0);

        // glitch: two samples only
        coin10_raw = 1'b1;
        repeat (2) @(negedge clk);
        coin10_raw = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk($sformatf("glitch_%0d", i), {29'd0, pending, x}, 32'd0);
        end

        // fill with hold, fifth coin bounces
        hold = 1'b1;
        ret_cnt = 0;
        insert(2'b01);
        insert(2'b10);
        insert(2'b10);
        insert(2'b01);
        insert(2'b10);
        chk("fill_pending", 32'(pending), 32'd4);
        chk("fill_ret", 32'(ret_cnt), 32'd1);
        drain_exp[0] = 2'b01;
        drain_exp[1] = 2'b10;
        drain_exp[2] = 2'b10;
        drain_exp[3] = 2'b01;
        drain_exp[4] = 2'b00;
        hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("drain_x_%0d", i), 32'(x), 32'(drain_exp[i]));
        end
        chk("drain_pending", 32'(pending), 32'd0);
`ifdef COIN_ACCEPTOR_STATS_EN
        chk("credit_35", 32'(credit_total), 32'd35);
`endif

        // simultaneous coins with free=1 and free=0
        hold = 1'b1;
        insert(2'b01);
        insert(2'b01);
        insert(2'b01);
        ret_cnt = 0;
        insert(2'b11);
        chk("sim1_pending", 32'(pending), 32'd4);
        chk("sim1_ret", 32'(ret_cnt), 32'd1);
        ret_cnt = 0;
        hist = '0;
        insert(2'b11);
        chk("sim0_ret", 32'(ret_cnt), 32'd2);
        chk("sim0_ret_adjacent", 32'(|(hist & (hist >> 1))), 32'd1);
        chk("sim0_pending", 32'(pending), 32'd4);
        hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("sim_drain_x_%0d", i), 32'(x), (i < 4) ? 32'd1 : 32'd0);
        end
`ifdef COIN_ACCEPTOR_STATS_EN
        chk("credit_55", 32'(credit_total), 32'd55);
`endif

        // async reset with three buffered coins and one in flight
        hold = 1'b1;
        insert(2'b01);
        insert(2'b10);
        insert(2'b01);
        chk("prereset_pending", 32'(pending), 32'd3);
        coin10_raw = 1'b1;
        repeat (3) @(negedge clk);
        hold = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_x", 32'(x), 32'd0);
        chk("arst_pending", 32'(pending), 32'd0);
        chk("arst_ret", 32'(coin_return), 32'd0);
`ifdef COIN_ACCEPTOR_STATS_EN
        chk("arst_credit", 32'(credit_total), 32'd0);
`endif
        @(negedge clk) reset = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_x_%0d", i), 32'(x), (i == 7) ? 32'd2 : 32'd0);
        end
        coin10_raw = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_pending", 32'(pending), 32'd0);

`ifdef COIN_ACCEPTOR_STATS_EN
        chk("credit_10", 32'(credit_total), 32'd10);
        force dut.credit_total = 16'hFFF8;
        @(negedge clk);
        release dut.credit_total;
        insert(2'b10);
        chk("credit_sat", 32'(credit_total), 32'h0000FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
